// File: rtl/sdram_arbiter.sv
// Two-master Wishbone pipelined arbiter in front of the SDRAM controller slave port.
// Ownership lasts a whole bus cycle; an outstanding-request counter routes acks and throttles strobes.
module sdram_arbiter #(
  parameter int AWIDTH  = 26,
  parameter int DWIDTH  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master 0 (CPU)
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [DWIDTH/8-1:0]   m0_sel_i,
  input  logic [AWIDTH-1:0]     m0_adr_i,
  input  logic [DWIDTH-1:0]     m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_stall_o,
  output logic [DWIDTH-1:0]     m0_dat_o,
  // master 1 (DMA / video)
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [DWIDTH/8-1:0]   m1_sel_i,
  input  logic [AWIDTH-1:0]     m1_adr_i,
  input  logic [DWIDTH-1:0]     m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_stall_o,
  output logic [DWIDTH-1:0]     m1_dat_o,
  // SDRAM controller slave port
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [DWIDTH/8-1:0]   s_sel_o,
  output logic [AWIDTH-1:0]     s_adr_o,
  output logic [DWIDTH-1:0]     s_dat_o,
  input  logic [DWIDTH-1:0]     s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_stall_i,
  output logic                  ovf_err_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1, S_DRAIN} state_t;

  state_t        state_q, state_d, cur_state;
  logic [CW-1:0] count_q, count_d;
  logic          last_grant_q, last_grant_d;
  logic          ovf_q, ovf_d;
  logic          gnt1, own_cyc, own_stb, limit, accept;

  // Outputs fall back to the idle view while reset is held.
  assign cur_state = rst_i ? S_IDLE : state_q;
  assign gnt1      = (cur_state == S_GRANT1) || ((cur_state == S_DRAIN) && last_grant_q);
  assign own_cyc   = gnt1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb   = gnt1 ? m1_stb_i : m0_stb_i;
  assign limit     = (count_q == MAX_C);

  assign s_adr_o   = gnt1 ? m1_adr_i : m0_adr_i;
  assign s_we_o    = gnt1 ? m1_we_i  : m0_we_i;
  assign s_sel_o   = gnt1 ? m1_sel_i : m0_sel_i;
  assign s_dat_o   = gnt1 ? m1_dat_i : m0_dat_i;
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign ovf_err_o = ovf_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    m0_stall_o   = 1'b1;
    m1_stall_o   = 1'b1;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
          state_d      = S_GRANT0;
          last_grant_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = S_GRANT1;
          last_grant_d = 1'b1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        s_cyc_o = 1'b1;
        // A strobe is only forwarded while the owner still holds cyc.
        s_stb_o = own_cyc && own_stb && !limit;
        if (gnt1) begin
          m1_stall_o = s_stall_i || limit;
          m1_ack_o   = s_ack_i;
        end else begin
          m0_stall_o = s_stall_i || limit;
          m0_ack_o   = s_ack_i;
        end
        if (!own_cyc) state_d = (count_d != '0) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        s_cyc_o  = 1'b1;
        m1_ack_o = s_ack_i && gnt1;
        m0_ack_o = s_ack_i && !gnt1;
        if (count_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = s_stb_o && !s_stall_i;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (accept && !s_ack_i) begin
      count_d = count_q + CW'(1);
    end else if (!accept && s_ack_i) begin
      if (count_q == '0) ovf_d = 1'b1;
      else               count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Random two-master traffic against an in-order controller model, scoreboarded by a monitor,
// followed by directed arbitration, limit, overflow and reset scenarios.
module tb_sdram_arbiter;
  localparam int MAX_OUT = 4;

  typedef struct {
    int          id;
    logic        we;
    logic [25:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  logic        clk, rst;
  logic        mcyc[2], mstb[2], mwe[2], mack[2], mstall[2];
  logic [3:0]  msel[2];
  logic [25:0] madr[2];
  logic [31:0] mdat[2], mdat_o[2];
  logic        s_cyc, s_stb, s_we, s_ack, s_stall, ovf;
  logic [3:0]  s_sel;
  logic [25:0] s_adr;
  logic [31:0] s_dat_o, s_dat_i;

  int   errors = 0;
  int   checks = 0;
  int   pend[2];
  bit   done;
  req_t fwd_q[$];
  req_t ack_q[$];
  req_t slv_q[$];

  sdram_arbiter #(.AWIDTH(26), .DWIDTH(32), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_sel_i(msel[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_ack_o(mack[0]), .m0_stall_o(mstall[0]),
    .m0_dat_o(mdat_o[0]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_sel_i(msel[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_ack_o(mack[1]), .m1_stall_o(mstall[1]),
    .m1_dat_o(mdat_o[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_stall_i(s_stall),
    .ovf_err_o(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] hash(input logic [25:0] a);
    return {6'h2B, a} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got bound expired expected event", name);
  endtask

  // Bus master: bursts of 1..6 requests, sometimes dropping cyc before its acks return.
  task automatic master_run(input int id, input int nb);
    req_t r;
    int   n, issued, g;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 3)) tick();
      mcyc[id] = 1'b1;
      n = $urandom_range(1, 6);
      issued = 0;
      g = 0;
      while (issued < n && g < 400) begin
        mstb[id] = ($urandom_range(0, 3) != 0);
        madr[id] = 26'($urandom);
        mwe[id]  = 1'($urandom);
        msel[id] = 4'($urandom);
        mdat[id] = $urandom;
        smp();
        if (mstb[id] && !mstall[id]) begin
          r.id = id; r.we = mwe[id]; r.adr = madr[id]; r.sel = msel[id]; r.dat = mdat[id];
          fwd_q.push_back(r);
          pend[id]++;
          issued++;
        end
        tick();
        g++;
      end
      if (g >= 400) fail("grant_timeout");
      mstb[id] = 1'b0;
      if ($urandom_range(0, 2) != 0) begin
        g = 0;
        while (pend[id] != 0 && g < 400) begin
          tick();
          g++;
        end
        if (g >= 400) fail("ack_timeout");
      end
      mcyc[id] = 1'b0;
      tick();
    end
  endtask

  // In-order controller model: random stall, acks the oldest accepted request.
  task automatic slave_run();
    req_t r;
    while (!done) begin
      tick();
      s_stall = ($urandom_range(0, 3) == 0);
      if (slv_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        r = slv_q.pop_front();
        s_ack = 1'b1;
        s_dat_i = r.we ? $urandom : hash(r.adr);
      end else begin
        s_ack = 1'b0;
        s_dat_i = $urandom;
      end
      smp();
      if (s_stb && !s_stall) begin
        r.id = 0; r.we = s_we; r.adr = s_adr; r.sel = s_sel; r.dat = s_dat_o;
        slv_q.push_back(r);
      end
    end
    s_ack = 1'b0;
    s_stall = 1'b0;
  endtask

  // Monitor: ack routing/data by issue order, forwarded fields, outstanding limit.
  task automatic monitor_run();
    req_t r;
    int   outst;
    while (!done) begin
      @(negedge clk);
      #1;
      outst = ack_q.size();
      if (s_ack) begin
        if (ack_q.size() == 0) begin
          fail("ack_unexpected");
        end else begin
          r = ack_q.pop_front();
          chk("ack_route", {30'd0, mack[1], mack[0]}, (r.id == 1) ? 32'd2 : 32'd1);
          if (!r.we) chk("rd_data", mdat_o[r.id], hash(r.adr));
          pend[r.id]--;
          $display("ack m%0d %s adr=%07h", r.id, r.we ? "wr" : "rd", r.adr);
        end
      end else if (mack[0] || mack[1]) begin
        fail("ack_without_s_ack");
      end
      if (s_stb && !s_stall) begin
        chk("limit_respected", {31'd0, outst < MAX_OUT}, 32'd1);
        if (fwd_q.size() == 0) begin
          fail("fwd_unexpected");
        end else begin
          r = fwd_q.pop_front();
          chk("fwd_adr", {6'd0, s_adr}, {6'd0, r.adr});
          chk("fwd_ctl", {27'd0, s_we, s_sel}, {27'd0, r.we, r.sel});
          chk("fwd_dat", s_dat_o, r.dat);
          ack_q.push_back(r);
        end
      end
      if (fwd_q.size() != 0) begin
        fail("fwd_dropped");
        fwd_q.delete();
      end
    end
  endtask

  initial begin
    int acc, a0, a1, g;
    rst = 1'b1;
    s_ack = 1'b0; s_stall = 1'b0; s_dat_i = '0;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 0; mstb[i] = 0; mwe[i] = 0; msel[i] = 0; madr[i] = 0; mdat[i] = 0; pend[i] = 0;
    end
    done = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    fork
      begin
        fork
          master_run(0, 12);
          master_run(1, 12);
        join
        g = 0;
        while (ack_q.size() != 0 && g < 300) begin
          tick();
          g++;
        end
        done = 1'b1;
      end
      slave_run();
      monitor_run();
    join
    chk("random_drained", ack_q.size(), 0);
    chk("random_no_ovf", {31'd0, ovf}, 32'd0);

    // Reset state.
    tick(); rst = 1'b1; s_ack = 0; s_stall = 0;
    smp(); chk("in_rst_stalls", {30'd0, mstall[1], mstall[0]}, 32'd3);
    tick(); rst = 1'b0;
    smp();
    chk("rst_stalls", {30'd0, mstall[1], mstall[0]}, 32'd3);
    chk("rst_cyc_stb", {30'd0, s_cyc, s_stb}, 32'd0);
    chk("rst_acks_ovf", {29'd0, mack[1], mack[0], ovf}, 32'd0);

    // Simultaneous request: m0 first, then m1, then m0 again.
    tick(); mcyc[0] = 1; mcyc[1] = 1;
    smp(); chk("arb_idle_cyc", {31'd0, s_cyc}, 32'd0);
    tick(); mstb[0] = 1; mwe[0] = 1; madr[0] = 26'h000100; mdat[0] = 32'hCAFEF00D; msel[0] = 4'hF;
    smp();
    chk("tie_m0_stalls", {30'd0, mstall[1], mstall[0]}, 32'd2);
    chk("wr_stb", {31'd0, s_stb}, 32'd1);
    chk("wr_adr", {6'd0, s_adr}, 32'h100);
    chk("wr_dat", s_dat_o, 32'hCAFEF00D);
    tick(); mstb[0] = 0; s_ack = 1;
    smp(); chk("wr_ack_route", {30'd0, mack[1], mack[0]}, 32'd1);
    tick(); s_ack = 0; mcyc[0] = 0;
    smp(); chk("no_stb_on_drop", {31'd0, s_stb}, 32'd0);
    tick(); smp(); chk("back_idle", {31'd0, s_cyc}, 32'd0);
    tick(); smp(); chk("m1_granted", {30'd0, mstall[1], mstall[0]}, 32'd1);
    tick(); mcyc[1] = 0;
    smp(); tick(); smp();
    tick(); mcyc[0] = 1; mcyc[1] = 1;
    smp(); tick(); smp(); chk("tie_m0_again", {30'd0, mstall[1], mstall[0]}, 32'd2);
    tick(); mcyc[0] = 0; mcyc[1] = 0;
    smp(); tick(); smp();

    // Outstanding limit on m1 with acks held off.
    tick(); mcyc[1] = 1; mstb[1] = 1; mwe[1] = 0; madr[1] = 26'h200;
    acc = 0;
    repeat (8) begin
      smp(); if (s_stb && !s_stall) acc++;
      tick();
    end
    chk("limit_accepts", acc, 4);
    s_ack = 1;
    smp();
    chk("limit_stall", {31'd0, mstall[1]}, 32'd1);
    chk("limit_ack_m1", {30'd0, mack[1], mack[0]}, 32'd2);
    tick(); s_ack = 0; acc = 0;
    repeat (4) begin
      smp(); if (s_stb && !s_stall) acc++;
      tick();
    end
    chk("one_ack_one_more", acc, 1);
    mstb[1] = 0; mcyc[1] = 0; mcyc[0] = 1; s_ack = 1; a0 = 0; a1 = 0;
    repeat (4) begin
      smp(); if (mack[0]) a0++; if (mack[1]) a1++;
      tick();
    end
    s_ack = 0;
    smp();
    chk("drain_acks_m1", a1, 4);
    chk("drain_acks_m0", a0, 0);
    chk("drain_m0_waits", {31'd0, mstall[0]}, 32'd1);
    tick(); smp(); chk("m0_after_drain", {31'd0, mstall[0]}, 32'd0);
    tick(); mcyc[0] = 0;
    smp(); tick(); smp();

    // Spurious ack in idle sets the sticky overflow flag.
    tick(); s_ack = 1;
    smp(); chk("spur_no_ack", {30'd0, mack[1], mack[0]}, 32'd0);
    tick(); s_ack = 0;
    smp(); chk("ovf_set", {31'd0, ovf}, 32'd1);
    tick(); smp(); tick(); smp(); chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    tick(); rst = 1;
    smp(); tick(); rst = 0;
    smp(); chk("ovf_cleared", {31'd0, ovf}, 32'd0);

    // Reset with three requests outstanding.
    tick(); mcyc[0] = 1; mstb[0] = 0;
    smp(); tick(); mstb[0] = 1; acc = 0;
    repeat (3) begin
      smp(); if (s_stb && !s_stall) acc++;
      tick();
    end
    chk("pre_rst_accepts", acc, 3);
    mstb[0] = 0; mcyc[0] = 0; rst = 1;
    smp(); chk("midrst_outputs", {29'd0, mstall[1], mstall[0], s_cyc}, 32'd6);
    tick(); rst = 0;
    smp(); chk("post_rst_outputs", {29'd0, mstall[1], mstall[0], s_cyc}, 32'd6);
    tick(); mcyc[0] = 1; mstb[0] = 1;
    smp(); tick(); acc = 0;
    repeat (6) begin
      smp(); if (s_stb && !s_stall) acc++;
      tick();
    end
    chk("post_rst_count", acc, 4);
    mcyc[0] = 0; mstb[0] = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
